// File: rtl/arb_mux_pkg.sv
// Shared definitions for the registered N:1 arbitrating mux.
package arb_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_t;

    localparam int MAX_NUM_IN = 16;

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps.
// Structure is rotate requests, priority-encode the lowest, rotate the grant back.
module rr_arbiter #(
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_IN-1:0] grant
);

    localparam int CW = SEL_W + 1;

    logic [NUM_IN-1:0] rot_req;
    logic [NUM_IN-1:0] rot_grant;
    logic [CW-1:0]     start;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic [CW-1:0] idx;
        logic          found;
        rot_req   = '0;
        rot_grant = '0;
        grant     = '0;
        found     = 1'b0;
        idx       = '0;

        start = {1'b0, ptr} + CW'(1);
        if (start >= CW'(NUM_IN)) start = '0;

        for (int k = 0; k < NUM_IN; k++) begin
            idx = start + CW'(k);
            if (idx >= CW'(NUM_IN)) idx = idx - CW'(NUM_IN);
            rot_req[k] = req[idx[SEL_W-1:0]];
        end

        for (int k = 0; k < NUM_IN; k++) begin
            if (rot_req[k] && !found) begin
                rot_grant[k] = 1'b1;
                found        = 1'b1;
            end
        end

        for (int k = 0; k < NUM_IN; k++) begin
            idx = start + CW'(k);
            if (idx >= CW'(NUM_IN)) idx = idx - CW'(NUM_IN);
            if (rot_grant[k]) grant[idx[SEL_W-1:0]] = en;
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// Registered N:1 datapath mux with per-channel valid/ready and fixed or
// round-robin channel selection; one-beat output register with full throughput.
module arb_mux_n
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        select,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    localparam int CW = SEL_W + 1;

    mux_mode_t         mode_e;
    logic              load_en;
    logic [NUM_IN-1:0] fixed_grant;
    logic [NUM_IN-1:0] rr_grant;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              xfer;
    logic [SEL_W-1:0]  rr_ptr;

    assign mode_e  = mux_mode_t'(mode);
    assign load_en = !out_valid || out_ready;

    // An out-of-range select (non-power-of-2 NUM_IN) simply yields no grant.
    always_comb begin
        fixed_grant = '0;
        if (CW'(select) < CW'(NUM_IN)) begin
            if (in_valid[select]) fixed_grant[select] = 1'b1;
        end
    end

    rr_arbiter #(.NUM_IN(NUM_IN)) u_rr_arbiter (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .en    (load_en),
        .grant (rr_grant)
    );

    assign grant    = (mode_e == MODE_RR) ? rr_grant : fixed_grant;
    assign in_ready = grant & {NUM_IN{load_en}};
    assign xfer     = |in_ready;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) grant_idx = SEL_W'(i);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_src   <= '0;
            rr_ptr    <= SEL_W'(NUM_IN - 1);
        end else if (xfer) begin
            out       <= in_data[grant_idx*WIDTH +: WIDTH];
            out_src   <= grant_idx;
            out_valid <= 1'b1;
            if (mode_e == MODE_RR) rr_ptr <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: a 4x32 instance and a 3x8 instance, with
// expected beats queued when a handshake is driven and popped a cycle later.
module tb_arb_mux_n;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  src;
    } beat_t;

    logic         clk;
    logic         rst_n;

    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic         mode;
    logic [1:0]   select;
    logic [31:0]  out;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_src;

    logic [23:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic         mode3;
    logic [1:0]   select3;
    logic [7:0]   out3;
    logic         out_valid3;
    logic         out_ready3;
    logic [1:0]   out_src3;

    beat_t sb4[$];
    beat_t sb3[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    arb_mux_n #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .select    (select),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    arb_mux_n #(.WIDTH(8), .NUM_IN(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .select    (select3),
        .out       (out3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_src   (out_src3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pop4(input string tag);
        beat_t b;
        n_cmp++;
        assert (sb4.size() > 0) else begin
            n_bad++;
            $error("FAIL %s_sb_empty: observed=0 expected=nonzero", tag);
        end
        if (sb4.size() > 0) begin
            b = sb4.pop_front();
            check({tag, "_data"},  64'(out),       64'(b.data));
            check({tag, "_src"},   64'(out_src),   64'(b.src));
            check({tag, "_valid"}, 64'(out_valid), 64'(1));
        end
    endtask

    task automatic pop3(input string tag);
        beat_t b;
        n_cmp++;
        assert (sb3.size() > 0) else begin
            n_bad++;
            $error("FAIL %s_sb_empty: observed=0 expected=nonzero", tag);
        end
        if (sb3.size() > 0) begin
            b = sb3.pop_front();
            check({tag, "_data"},  64'(out3),       64'(b.data));
            check({tag, "_src"},   64'(out_src3),   64'(b.src));
            check({tag, "_valid"}, 64'(out_valid3), 64'(1));
        end
    endtask

    initial begin
        logic [31:0] ch [4];
        logic [7:0]  ch3 [3];
        logic [3:0]  exp_rdy;

        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = '0;
        mode       = 1'b0;
        select     = '0;
        out_ready  = 1'b1;
        in_data3   = '0;
        in_valid3  = '0;
        mode3      = 1'b0;
        select3    = '0;
        out_ready3 = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_out",       64'(out),        64'(0));
        check("rst_out_valid", 64'(out_valid),  64'(0));
        check("rst_out_src",   64'(out_src),    64'(0));
        check("rst_in_ready",  64'(in_ready),   64'(0));
        check("rst3_valid",    64'(out_valid3), 64'(0));

        // Basic fixed select of channel 2.
        rst_n    = 1'b1;
        select   = 2'd2;
        in_data[2*32 +: 32] = 32'hDEAD_BEEF;
        in_valid = 4'b0100;
        #1 check("sel2_ready", 64'(in_ready), 64'(4'b0100));
        sb4.push_back('{32'hDEAD_BEEF, 4'd2});
        tick();
        pop4("sel2");

        // Asynchronous reset in the middle of a held beat.
        in_valid = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out",       64'(out),       64'(0));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_out_src",   64'(out_src),   64'(0));
        check("midrst_in_ready",  64'(in_ready),  64'(0));
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 4'b0100;
        #1 check("sel2b_ready", 64'(in_ready), 64'(4'b0100));
        sb4.push_back('{32'hDEAD_BEEF, 4'd2});
        tick();
        pop4("sel2b");

        // Fixed select of a channel that is not valid: no grant, beat drains.
        select   = 2'd1;
        in_valid = 4'b1101;
        #1 check("sel1_inv_ready", 64'(in_ready), 64'(0));
        tick();
        check("sel1_inv_drained", 64'(out_valid), 64'(0));
        check("sel1_inv_hold",    64'(out),       64'(32'hDEAD_BEEF));
        check("sel1_inv_src",     64'(out_src),   64'(2));

        // Round-robin fairness with all channels valid.
        for (int i = 0; i < 4; i++) begin
            ch[i] = 32'h1000_0000 + 32'(i * 17);
            in_data[i*32 +: 32] = ch[i];
        end
        mode     = 1'b1;
        in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            #1 check("rr_fair_ready", 64'(in_ready), 64'(exp_rdy));
            sb4.push_back('{ch[k % 4], 4'(k % 4)});
            tick();
            pop4("rr_fair");
        end

        // Skip invalid channels and wrap after channel 3.
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            exp_rdy = (k % 2 == 0) ? 4'b0010 : 4'b1000;
            #1 check("rr_skip_ready", 64'(in_ready), 64'(exp_rdy));
            sb4.push_back('{ch[(k % 2 == 0) ? 1 : 3], (k % 2 == 0) ? 4'd1 : 4'd3});
            tick();
            pop4("rr_skip");
        end

        // Backpressure holding 0xA5 from channel 1.
        in_data[1*32 +: 32] = 32'h0000_00A5;
        in_valid = 4'b0010;
        #1 check("bp_load_ready", 64'(in_ready), 64'(4'b0010));
        sb4.push_back('{32'h0000_00A5, 4'd1});
        tick();
        pop4("bp_load");
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_stall_ready", 64'(in_ready), 64'(0));
            tick();
            check("bp_stall_out",   64'(out),       64'(32'h0000_00A5));
            check("bp_stall_src",   64'(out_src),   64'(1));
            check("bp_stall_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", 64'(in_ready), 64'(4'b0100));
        sb4.push_back('{ch[2], 4'd2});
        tick();
        pop4("bp_release");
        in_valid = 4'b0000;
        tick();
        check("final_drain_valid", 64'(out_valid), 64'(0));

        // Three-channel, 8-bit instance: out-of-range select, then wrap 2 -> 0.
        for (int i = 0; i < 3; i++) begin
            ch3[i] = 8'h30 + 8'(i);
            in_data3[i*8 +: 8] = ch3[i];
        end
        mode3     = 1'b0;
        select3   = 2'd3;
        in_valid3 = 3'b111;
        #1 check("n3_sel3_ready", 64'(in_ready3), 64'(0));
        tick();
        check("n3_sel3_valid", 64'(out_valid3), 64'(0));
        select3 = 2'd2;
        #1 check("n3_sel2_ready", 64'(in_ready3), 64'(3'b100));
        sb3.push_back('{32'(ch3[2]), 4'd2});
        tick();
        pop3("n3_sel2");
        mode3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 check("n3_rr_ready", 64'(in_ready3), 64'(3'b001 << (k % 3)));
            sb3.push_back('{32'(ch3[k % 3]), 4'(k % 3)});
            tick();
            pop3("n3_rr");
        end

        check("sb4_leftover", 64'(sb4.size()), 64'(0));
        check("sb3_leftover", 64'(sb3.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arb_mux_n.md
Name: arb_mux_n

Overview:
- Parametrised, registered N:1 datapath mux. Successor to the combinational 2:1 select mux.
- Adds per-channel valid/ready handshakes and a one-beat output register.
- Two selection modes: fixed select (legacy behaviour) and round-robin arbitration.
- Sits between multiple producers (e.g. ALU result, memory read, CSR read) and a single consumer stage in the pipeline.

Parameters:
- WIDTH, 32, data width of every input channel and of OUT.
- NUM_IN, 4, number of input channels (2..16).
- SEL_W, $clog2(NUM_IN), width of SELECT and OUT_SRC (derived, do not override).

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- IN_DATA  input  NUM_IN*WIDTH  packed channel data; channel i occupies [i*WIDTH +: WIDTH].
- IN_VALID  input  NUM_IN  per-channel valid.
- IN_READY  output  NUM_IN  per-channel ready; combinational, one-hot or zero.
- MODE  input  1  0 = fixed select, 1 = round-robin.
- SELECT  input  SEL_W  channel index used in fixed mode.
- OUT  output  WIDTH  registered output data.
- OUT_VALID  output  1  OUT holds an unconsumed beat.
- OUT_READY  input  1  consumer accepts OUT this cycle.
- OUT_SRC  output  SEL_W  index of the channel that produced OUT.

Behaviour:
- Reset (RST_N low, asynchronous): OUT=0, OUT_VALID=0, OUT_SRC=0, rr_ptr=NUM_IN-1. The first round-robin grant is therefore channel 0. A reset asserted mid-transfer discards the held beat.
- load_en = !OUT_VALID | OUT_READY. The register accepts a beat when it is empty or is being drained in the same cycle, giving full throughput.
- Fixed mode grant:
  - grant = one-hot(SELECT) when IN_VALID[SELECT] is high.
  - Otherwise no grant.
  - SELECT >= NUM_IN (non-power-of-2 NUM_IN) produces no grant.
- Round-robin grant: search IN_VALID starting at rr_ptr+1, wrapping modulo NUM_IN; the first valid channel wins. No valid channel means no grant.
- IN_READY[i] = grant[i] & load_en. Ready may depend on IN_VALID (combinational), but valid must not depend on ready.
- Transfer on channel i: IN_VALID[i] & IN_READY[i]. On the next edge:
  - OUT <= channel i data.
  - OUT_SRC <= i.
  - OUT_VALID <= 1.
- Latency: 1 cycle from input handshake to OUT_VALID.
- If OUT_READY & OUT_VALID and there is no new transfer: OUT_VALID <= 0. OUT and OUT_SRC hold their last values.
- Stall (OUT_VALID & !OUT_READY): OUT and OUT_SRC are stable, and every IN_READY is 0.
- rr_ptr updates to the granted index only on an actual transfer, and only in round-robin mode.
  - Fixed mode leaves rr_ptr untouched.
  - A MODE change takes effect on the next arbitration and does not disturb a held beat.
- Simultaneous drain and load: both occur in one cycle, so OUT_VALID stays 1 with the new data.
- rr_ptr wrap-around: after a grant to NUM_IN-1, the search starts at 0.
- NUM_IN=2, MODE=0 is functionally the old 2:1 mux plus one register stage.

Decomposition:
- Package arb_mux_pkg:
  - typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mux_mode_t.
  - Constant MAX_NUM_IN=16.
- Sub-module rr_arbiter (parameter NUM_IN): inputs req, ptr, en; output one-hot grant. Purely combinational, with a rotate / priority-encode / rotate-back structure.
- Top level holds the output register, rr_ptr, the fixed-mode decode and the data select (indexed part-select on IN_DATA by the encoded grant).

Test Plan:
- Reset and basic select:
  - Stimulus: RST_N low mid-beat, then release. MODE=0, SELECT=2, IN_VALID=4'b0100, IN_DATA ch2=32'hDEAD_BEEF, OUT_READY=1.
  - Required: all outputs 0 during reset; IN_READY=4'b0100; one cycle later OUT=32'hDEAD_BEEF, OUT_SRC=2, OUT_VALID=1.
- Fixed select, invalid channel:
  - Stimulus: SELECT=1, IN_VALID=4'b1101.
  - Required: IN_READY=0; OUT_VALID falls to 0 after the current beat drains.
- Round-robin fairness:
  - Stimulus: MODE=1, IN_VALID=4'b1111 held, OUT_READY=1 for 8 cycles.
  - Required: OUT_SRC sequence 0,1,2,3,0,1,2,3; one beat every cycle.
- Round-robin skip and wrap:
  - Stimulus: IN_VALID=4'b1010 after a grant to ch3.
  - Required: next grants are 1, 3, 1, 3.
- Backpressure:
  - Stimulus: OUT_READY=0 for 3 cycles with OUT_VALID=1 and OUT=32'h0000_00A5.
  - Required: OUT, OUT_SRC stable and IN_READY=0 throughout; on OUT_READY=1, the drain and the new load happen in the same cycle.
- Parameter sweep:
  - Stimulus: NUM_IN=3, WIDTH=8, SELECT=3 in fixed mode.
  - Required: no grant. In round-robin, the sequence wraps 2 -> 0.
